// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with data-memory handshake and load formatting
// Optional misaligned-access trap: define MEM_MISALIGN_CHECK_EN.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_valid,
    input  logic        MEM_read,
    input  logic        MEM_write,
    input  logic [2:0]  MEM_funct3,
    input  logic [31:0] MEM_alu_out,
    input  logic [31:0] MEM_rs2_out,
    input  logic        MEM_advance,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        MEM_stall,
    output logic [31:0] MEM_load_data,
    output logic        MEM_misaligned
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] hold_q;
    logic        access, is_write, is_read, misaligned, req, use_rdata;
    logic [31:0] fmt_src, fmt_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign access   = MEM_valid & (MEM_read | MEM_write);
    assign is_write = MEM_write;
    assign is_read  = MEM_read & ~MEM_write;

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        if (access) begin
            case (MEM_funct3[1:0])
                2'b01:   misaligned = MEM_alu_out[0];
                2'b10:   misaligned = |MEM_alu_out[1:0];
                default: misaligned = 1'b0;
            endcase
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    // DONE suppresses the request so a stalled-downstream load is never reissued.
    assign req       = rst_n & access & ~misaligned & (state != DONE);
    assign use_rdata = req & dmem_resp;

    assign dmem_read      = req & is_read;
    assign dmem_write     = req & is_write;
    assign dmem_address   = {MEM_alu_out[31:2], 2'b00};
    assign MEM_stall      = req & ~dmem_resp;
    assign MEM_misaligned = rst_n & misaligned;

    always_comb begin
        dmem_byte_enable = 4'b0000;
        dmem_wdata       = MEM_rs2_out;
        case (MEM_funct3[1:0])
            2'b00: begin
                dmem_byte_enable = 4'b0001 << MEM_alu_out[1:0];
                dmem_wdata       = {4{MEM_rs2_out[7:0]}};
            end
            2'b01: begin
                dmem_byte_enable = 4'b0011 << {MEM_alu_out[1], 1'b0};
                dmem_wdata       = {2{MEM_rs2_out[15:0]}};
            end
            default: begin
                dmem_byte_enable = 4'b1111;
                dmem_wdata       = MEM_rs2_out;
            end
        endcase
        if (!(req && is_write))
            dmem_byte_enable = 4'b0000;
    end

    assign fmt_src = use_rdata ? dmem_rdata : hold_q;

    always_comb begin
        sel_byte = fmt_src[7:0];
        case (MEM_alu_out[1:0])
            2'b00: sel_byte = fmt_src[7:0];
            2'b01: sel_byte = fmt_src[15:8];
            2'b10: sel_byte = fmt_src[23:16];
            2'b11: sel_byte = fmt_src[31:24];
        endcase
        sel_half = MEM_alu_out[1] ? fmt_src[31:16] : fmt_src[15:0];
        case (MEM_funct3)
            3'b000:  fmt_word = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  fmt_word = {{16{sel_half[15]}}, sel_half};
            3'b100:  fmt_word = {24'h0, sel_byte};
            3'b101:  fmt_word = {16'h0, sel_half};
            default: fmt_word = fmt_src;
        endcase
        MEM_load_data = (access && is_read && !misaligned) ? fmt_word : 32'h0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    if (dmem_resp)
                        state_nxt = MEM_advance ? IDLE : DONE;
                    else
                        state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Losing the access (flush) abandons the request rather than waiting.
                if (!access)
                    state_nxt = IDLE;
                else if (dmem_resp)
                    state_nxt = MEM_advance ? IDLE : DONE;
            end
            DONE: begin
                if (MEM_advance)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            hold_q <= 32'h0;
        end else begin
            state <= state_nxt;
            if (use_rdata)
                hold_q <= dmem_rdata;
        end
    end

endmodule
